// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// - ADDR_WIDTH / REG_WIDTH: the core's memory address and register (byte) widths.
// - ld_state_e: 3-bit loader FSM encoding, LD_IDLE .. LD_ERROR.
package mem_loader_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned REG_WIDTH  = 8;

  // LD_FLUSH is the cycle in which the final byte is still being written. Reads and
  // the core release both wait for it, so nobody ever observes a half-written image.
  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_LOAD    = 3'd1,
    LD_FLUSH   = 3'd2,
    LD_VERIFY  = 3'd3,
    LD_CHECK   = 3'd4,
    LD_RELEASE = 3'd5,
    LD_DONE    = 3'd6,
    LD_ERROR   = 3'd7
  } ld_state_e;

endpackage

// File: rtl/mem_loader_checksum.sv
// ld_checksum: modulo-2^Width byte accumulator.
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset, clears the sum
//   clr_i    synchronous clear (wins over en_i)
//   en_i     add din_i to the sum this cycle
//   din_i    byte to accumulate
//   sum_o    registered running sum
module ld_checksum #(
  parameter int unsigned Width = mem_loader_pkg::REG_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mem_loader.sv
// mem_loader: boot-time program loader in front of mem and fetcher.
// Accepts a byte stream (valid/ready), writes it to mem starting at base_addr, optionally
// reads the region back and compares checksums, then releases the core from reset and
// pulses trigger_program.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a load (honoured in IDLE, DONE, ERROR only)
//   base_addr, length          load region, latched on start
//   verify_en                  enable checksum readback, latched on start
//   s_valid, s_data, s_ready   byte stream handshake
//   mem_we, mem_addr, mem_din  registered write/read port to mem
//   mem_dout                   mem read data, valid one cycle after mem_addr
//   cpu_hold                   core held in reset while high
//   trigger_program            one-cycle pulse when the core is released
//   done, error                completion / failure levels
//   err_addr                   base_addr of the failing load
module mem_loader #(
  parameter int unsigned ADDR_WIDTH = mem_loader_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = mem_loader_pkg::REG_WIDTH,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  verify_en,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  cpu_hold,
  output logic                  trigger_program,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  import mem_loader_pkg::*;

  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] One    = ADDR_WIDTH'(1);

  ld_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, len_q, cnt_q;
  logic                  verify_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  rd_vld_q;   // a read address is on mem_addr this cycle
  logic                  dat_vld_q;  // mem_dout holds read data this cycle
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [DATA_WIDTH-1:0] wsum, rsum;

  logic                  start_ok;
  logic                  range_bad;
  logic                  hs;
  logic                  last_byte;
  logic                  issue_rd;
  logic                  err_set;
  logic [ADDR_WIDTH:0]   end_addr;

  // One extra bit so base+length cannot wrap past the check.
  assign end_addr  = {1'b0, base_addr} + {1'b0, length};
  assign range_bad = end_addr > DepthExt;

  assign hs        = s_valid && (state_q == LD_LOAD);
  assign last_byte = cnt_q == (len_q - One);

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    issue_rd = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) begin
          start_ok = 1'b1;
          if (range_bad) begin
            state_d = LD_ERROR;
            err_set = 1'b1;
          end else if (length == '0) begin
            state_d = LD_FLUSH;
          end else begin
            state_d = LD_LOAD;
          end
        end
      end
      LD_LOAD: begin
        if (hs && last_byte) begin
          state_d = LD_FLUSH;
        end
      end
      LD_FLUSH: begin
        // The first read address is registered here, so it reaches mem the cycle after
        // the final write and never collides with it.
        if (verify_q && (len_q != '0)) begin
          state_d  = LD_VERIFY;
          issue_rd = 1'b1;
        end else begin
          state_d = LD_RELEASE;
        end
      end
      LD_VERIFY: begin
        issue_rd = cnt_q < len_q;
        // No address in flight means the last read's data is on mem_dout now and is
        // accumulated at this edge.
        if (!rd_vld_q) begin
          state_d = LD_CHECK;
        end
      end
      LD_CHECK: begin
        if (rsum == wsum) begin
          state_d = LD_RELEASE;
        end else begin
          state_d = LD_ERROR;
          err_set = 1'b1;
        end
      end
      LD_RELEASE: state_d = LD_DONE;
      default:    state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      verify_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rd_vld_q   <= 1'b0;
      dat_vld_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      we_q      <= hs;
      rd_vld_q  <= issue_rd;
      dat_vld_q <= rd_vld_q;
      if (start_ok) begin
        base_q   <= base_addr;
        len_q    <= length;
        verify_q <= verify_en;
        cnt_q    <= '0;
      end else if (hs) begin
        addr_q <= base_q + cnt_q;
        din_q  <= s_data;
        // Rewind on the last byte so the same counter indexes the readback.
        cnt_q  <= last_byte ? '0 : cnt_q + One;
      end else if (issue_rd) begin
        addr_q <= base_q + cnt_q;
        cnt_q  <= cnt_q + One;
      end
      if (err_set) begin
        err_addr_q <= start_ok ? base_addr : base_q;
      end
    end
  end

  ld_checksum #(
    .Width (DATA_WIDTH)
  ) u_wsum (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (start_ok),
    .en_i    (hs),
    .din_i   (s_data),
    .sum_o   (wsum)
  );

  ld_checksum #(
    .Width (DATA_WIDTH)
  ) u_rsum (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (start_ok),
    .en_i    (dat_vld_q),
    .din_i   (mem_dout),
    .sum_o   (rsum)
  );

  assign s_ready         = state_q == LD_LOAD;
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_din         = din_q;
  assign cpu_hold        = !((state_q == LD_RELEASE) || (state_q == LD_DONE));
  assign trigger_program = state_q == LD_RELEASE;
  assign done            = (state_q == LD_RELEASE) || (state_q == LD_DONE);
  assign error           = state_q == LD_ERROR;
  assign err_addr        = err_addr_q;

endmodule
